// File: rtl/quad_step_decoder_if.sv
// Signal bundle for the quadrature step decoder: raw phases and error clear in,
// decoded step/direction/error/state out.
interface quad_step_decoder_if;
  logic       PhaseA;
  logic       PhaseB;
  logic       ErrClr;
  logic       Step;
  logic       UpOrDown;
  logic       ErrPulse;
  logic       ErrSticky;
  logic [1:0] PhaseState;

  modport master (
    output PhaseA, PhaseB, ErrClr,
    input  Step, UpOrDown, ErrPulse, ErrSticky, PhaseState
  );

  modport slave (
    input  PhaseA, PhaseB, ErrClr,
    output Step, UpOrDown, ErrPulse, ErrSticky, PhaseState
  );
endinterface

// File: rtl/quad_step_decoder.sv
// x4 quadrature decoder: two-flop synchroniser, per-channel persistence filter,
// Gray-step decode into a one-cycle Step pulse with held direction and error flags.
module quad_step_decoder #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned FCNT_W     = 8
) (
  input logic                Clk,
  input logic                reset,
  quad_step_decoder_if.slave bus
);

  typedef enum logic {INIT, RUN} state_t;

  state_t                   state, state_nx;
  logic                     init_cnt;
  logic [1:0]               s1, s2;
  logic [1:0]               filt, filt_nx, filt_d;
  logic [1:0][FCNT_W-1:0]   cnt, cnt_nx, cnt_d;
  logic                     step_q, dir_q, err_q, sticky_q;
  logic                     step_d, dir_d, err_d, sticky_d;

  function automatic logic [1:0] up_succ(input logic [1:0] v);
    case (v)
      2'b00:   up_succ = 2'b10;
      2'b10:   up_succ = 2'b11;
      2'b11:   up_succ = 2'b01;
      default: up_succ = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] dn_succ(input logic [1:0] v);
    case (v)
      2'b00:   dn_succ = 2'b01;
      2'b01:   dn_succ = 2'b11;
      2'b11:   dn_succ = 2'b10;
      default: dn_succ = 2'b00;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= 1'b0;
    end else begin
      state    <= state_nx;
      init_cnt <= (state == INIT) && !init_cnt;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == INIT && init_cnt)
      state_nx = RUN;
  end

  // Per-channel persistence filter; bit 1 is channel A, bit 0 is channel B.
  always_comb begin
    filt_nx = filt;
    cnt_nx  = cnt;
    for (int unsigned i = 0; i < 2; i++) begin
      if (s2[i] == filt[i]) begin
        cnt_nx[i] = '0;
      end else if (cnt[i] == FCNT_W'(FILTER_LEN - 1)) begin
        filt_nx[i] = s2[i];
        cnt_nx[i]  = '0;
      end else begin
        cnt_nx[i] = cnt[i] + FCNT_W'(1);
      end
    end
  end

  // In INIT the filter loads s1, the value s2 takes at this same edge, so the
  // filtered state already agrees with s2 on the first RUN edge.
  always_comb begin
    filt_d = filt_nx;
    cnt_d  = cnt_nx;
    step_d = 1'b0;
    err_d  = 1'b0;
    dir_d  = dir_q;
    if (state == INIT) begin
      filt_d = s1;
      cnt_d  = '0;
    end else if (filt_nx != filt) begin
      if (filt_nx == up_succ(filt)) begin
        step_d = 1'b1;
        dir_d  = 1'b1;
      end else if (filt_nx == dn_succ(filt)) begin
        step_d = 1'b1;
        dir_d  = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    sticky_d = err_d | (sticky_q & ~bus.ErrClr);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      filt     <= '0;
      cnt      <= '0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      dir_q    <= 1'b1;
    end else begin
      s1       <= {bus.PhaseA, bus.PhaseB};
      s2       <= s1;
      filt     <= filt_d;
      cnt      <= cnt_d;
      step_q   <= step_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      dir_q    <= dir_d;
    end
  end

  assign bus.Step       = step_q;
  assign bus.ErrPulse   = err_q;
  assign bus.ErrSticky  = sticky_q;
  assign bus.UpOrDown   = dir_q;
  assign bus.PhaseState = filt;

endmodule
